// File: rtl/carry_save_mult_pkg.sv
`default_nettype none
// ============================================================================
// carry_save_mult_pkg : shared width constant and product-width helper
// Rev 1.0
// ============================================================================
package carry_save_mult_pkg;

  localparam int CSM_WIDTH = 8;

  function automatic int csm_pdt_width(input int width);
    return 2 * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/carry_save_mult_if.sv
`default_nettype none
// ============================================================================
// carry_save_mult_if : operand/product bundle of the carry-save multiplier
// Rev 1.0
// ============================================================================
interface carry_save_mult_if
  import carry_save_mult_pkg::*;
#(
  parameter int WIDTH = CSM_WIDTH
);

  logic [WIDTH-1:0]                i0;
  logic [WIDTH-1:0]                i1;
  logic [csm_pdt_width(WIDTH)-1:0] pdt;

  modport master (output i0, output i1, input pdt);
  modport slave  (input i0, input i1, output pdt);

endinterface
`default_nettype wire

// File: rtl/carry_save_mult_csa_full_adder.sv
`default_nettype none
// ============================================================================
// csa_full_adder : one-bit full adder cell for the array and the merge adder
// Rev 1.0
// ============================================================================
module csa_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule
`default_nettype wire

// File: rtl/carry_save_mult.sv
`default_nettype none
// ============================================================================
// carry_save_mult : unsigned carry-save array multiplier, registered product
// Rev 1.0
// ============================================================================
module carry_save_mult
  import carry_save_mult_pkg::*;
#(
  parameter int WIDTH = CSM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  carry_save_mult_if.slave mul_io
);

  localparam int PW = csm_pdt_width(WIDTH);

  logic [PW-1:0] pdt_d;
  logic [PW-1:0] pdt_q;

  // Row j holds sum bits of weight 2^(j+k) and carry bits of weight 2^(j+k+1).
  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;

    if (j == 0) begin : g_first
      assign w_s = mul_io.i0 & {WIDTH{mul_io.i1[0]}};
      assign w_c = '0;
    end else begin : g_csa
      for (genvar k = 0; k < WIDTH; k++) begin : g_col
        logic w_pp;
        logic w_b;

        assign w_pp = mul_io.i0[k] & mul_io.i1[j];

        if (k < WIDTH - 1) begin : g_mid
          assign w_b = g_row[j-1].w_s[k+1];
        end else begin : g_top
          assign w_b = 1'b0;
        end

        csa_full_adder u_fa (
          .a_i   (w_pp),
          .b_i   (w_b),
          .cin_i (g_row[j-1].w_c[k]),
          .s_o   (w_s[k]),
          .cout_o(w_c[k])
        );
      end
    end

    assign pdt_d[j] = w_s[0];
  end

  // Ripple merge of the last row's sum and carry vectors into the upper half.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mrg
    logic w_a;
    logic w_ci;
    logic w_s;
    logic w_co;

    if (i == 0) begin : g_lsb
      assign w_ci = 1'b0;
    end else begin : g_chain
      assign w_ci = g_mrg[i-1].w_co;
    end

    if (i < WIDTH - 1) begin : g_body
      assign w_a             = g_row[WIDTH-1].w_s[i+1];
      assign pdt_d[WIDTH+i]  = w_s;
    end else begin : g_msb
      // The product always fits in PW bits, so sum and carry here are never both set.
      assign w_a             = 1'b0;
      assign pdt_d[WIDTH+i]  = w_s | w_co;
    end

    csa_full_adder u_fa (
      .a_i   (w_a),
      .b_i   (g_row[WIDTH-1].w_c[i]),
      .cin_i (w_ci),
      .s_o   (w_s),
      .cout_o(w_co)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pdt_q <= '0;
    end else begin
      pdt_q <= pdt_d;
    end
  end

  assign mul_io.pdt = pdt_q;

endmodule
`default_nettype wire

// File: tb/tb_carry_save_mult.sv
`default_nettype none
// ============================================================================
// tb_carry_save_mult : directed and exhaustive checks of carry_save_mult
// Rev 1.0
// ============================================================================
module tb_carry_save_mult;
  import carry_save_mult_pkg::*;

  localparam int W  = CSM_WIDTH;
  localparam int PW = 2 * W;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  carry_save_mult_if #(.WIDTH(W)) mul_if ();

  carry_save_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .mul_io(mul_if)
  );

  always #5 clk = ~clk;

  vec_t dir_vecs [13] = '{
    '{8'd23,  8'd14,  16'd322},
    '{8'd11,  8'd32,  16'd352},
    '{8'd45,  8'd19,  16'd855},
    '{8'd129, 8'd47,  16'd6063},
    '{8'd34,  8'd72,  16'd2448},
    '{8'd91,  8'd116, 16'd10556},
    '{8'd157, 8'd42,  16'd6594},
    '{8'd231, 8'd24,  16'd5544},
    '{8'd255, 8'd255, 16'hFE01},
    '{8'd255, 8'd1,   16'd255},
    '{8'd1,   8'd255, 16'd255},
    '{8'd128, 8'd128, 16'd16384},
    '{8'd255, 8'd0,   16'd0}
  };

  task automatic check_eq(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: pdt=%0d (0x%h) expected %0d (0x%h)", tag, act, act, exp, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b);
    mul_if.i0 = a;
    mul_if.i1 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] sa;
    logic [W-1:0] sb;

    rst = 1'b1;
    step(8'hFF, 8'hFF);
    check_eq("reset0", mul_if.pdt, '0);
    step(8'hFF, 8'hFF);
    check_eq("reset1", mul_if.pdt, '0);

    rst = 1'b0;
    step(8'h00, 8'h00);
    check_eq("zero", mul_if.pdt, '0);

    foreach (dir_vecs[n]) begin
      step(dir_vecs[n].a, dir_vecs[n].b);
      check_eq($sformatf("dir%0d_%0dx%0d", n, dir_vecs[n].a, dir_vecs[n].b),
               mul_if.pdt, dir_vecs[n].p);
    end

    // Operands change every cycle; one-cycle rst pulse in the middle of the stream.
    for (int j = 0; j < 16; j++) begin
      sa  = W'(j * 37 + 5);
      sb  = W'(200 - j * 11);
      rst = (j == 8);
      step(sa, sb);
      if (j == 8) begin
        check_eq("stream_rst", mul_if.pdt, '0);
      end else begin
        check_eq($sformatf("stream%0d", j), mul_if.pdt, PW'(int'(sa) * int'(sb)));
      end
    end
    rst = 1'b0;

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        step(W'(a), W'(b));
        check_eq($sformatf("sweep_%0dx%0d", a, b), mul_if.pdt, PW'(a * b));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
